// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_arb_owner_t;

    // The access currently owning the memory port.
    typedef struct packed {
        mem_arb_owner_t          owner;
        logic                    we;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
    } mem_arb_req_t;

    // On a tie the requester that was not granted last wins.
    function automatic mem_arb_owner_t pick_owner(input logic f_req,
                                                  input logic d_req,
                                                  input mem_arb_owner_t last);
        if (f_req && d_req) begin
            return (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end
        return d_req ? OWN_DATA : OWN_FETCH;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for a memory strobe: expires after TIMEOUT enabled cycles.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The counter only needs to reach TIMEOUT-1: the edge at that value is the last one waited.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = enable && (cnt_q == LAST);

    // Next count: clear on strobe assertion, advance while the strobe waits.
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, one access in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_read_ready,
    input  logic              m_write_ready,
    output logic              timeout_err
);

    mem_arb_state_t state_q, state_d;
    mem_arb_req_t   req_q, req_d;
    mem_arb_owner_t last_q, last_d;
    mem_arb_owner_t win;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic err_q, err_d;
    logic tmr_clear;
    logic tmr_expired;

    assign win = pick_owner(f_req, d_req, last_q);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  ((state_q == RD) || (state_q == WR)),
        .expired (tmr_expired)
    );

    // Next-state, grant and capture logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        last_d    = last_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = 1'b0;
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    tmr_clear = 1'b1;
                    last_d    = win;
                    if (win == OWN_DATA) begin
                        d_gnt       = 1'b1;
                        req_d.owner = OWN_DATA;
                        req_d.we    = d_we;
                        req_d.addr  = ARB_ADDR_W'(d_addr);
                        req_d.wdata = ARB_DATA_W'(d_wdata);
                        state_d     = d_we ? WR : RD;
                    end else begin
                        // Fetches are always reads; write data keeps its last value.
                        f_gnt       = 1'b1;
                        req_d.owner = OWN_FETCH;
                        req_d.we    = 1'b0;
                        req_d.addr  = ARB_ADDR_W'(f_addr);
                        state_d     = RD;
                    end
                end
            end
            RD: begin
                // Ready wins over expiry when both land on the same edge.
                if (m_read_ready) begin
                    state_d = DONE;
                    if (req_q.owner == OWN_DATA) d_rdata_d = m_rdata;
                    else                         f_rdata_d = m_rdata;
                end else if (tmr_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (req_q.owner == OWN_DATA) d_rdata_d = '0;
                    else                         f_rdata_d = '0;
                end
            end
            WR: begin
                if (m_write_ready) begin
                    state_d = DONE;
                end else if (tmr_expired) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    d_rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            last_q    <= OWN_FETCH;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            last_q    <= last_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign m_read      = (state_q == RD) && !req_q.we;
    assign m_write     = (state_q == WR) && req_q.we;
    assign m_addr      = ADDR_W'(req_q.addr);
    assign m_wdata     = DATA_W'(req_q.wdata);
    assign f_valid     = (state_q == DONE) && (req_q.owner == OWN_FETCH);
    assign d_valid     = (state_q == DONE) && (req_q.owner == OWN_DATA);
    assign f_rdata     = f_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width (equals ARCH_SIZE).
REQ-002 Parameter: DATA_W, 16, data width.
REQ-003 Parameter: TIMEOUT, 255, max cycles a memory strobe waits for ready.
REQ-004 Port: clock  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: f_req  in  1  fetch request, held until f_valid.
REQ-007 Port: f_addr  in  ADDR_W  fetch address, stable while f_req.
REQ-008 Port: f_gnt  out  1  one-cycle pulse, fetch request accepted.
REQ-009 Port: f_valid  out  1  one-cycle pulse, fetch complete.
REQ-010 Port: f_rdata  out  DATA_W  fetched word, valid with f_valid.
REQ-011 Port: d_req  in  1  data request, held until d_valid.
REQ-012 Port: d_we  in  1  1 = store, 0 = load.
REQ-013 Port: d_addr  in  ADDR_W  data address.
REQ-014 Port: d_wdata  in  DATA_W  store data.
REQ-015 Port: d_gnt  out  1  one-cycle pulse, data request accepted.
REQ-016 Port: d_valid  out  1  one-cycle pulse, data access complete.
REQ-017 Port: d_rdata  out  DATA_W  load data, valid with d_valid.
REQ-018 Port: m_read / m_write  out  1 each  memory strobes, never both high.
REQ-019 Port: m_addr / m_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-020 Port: m_rdata  in  DATA_W  memory read data.
REQ-021 Port: m_read_ready / m_write_ready  in  1 each  level completion, sampled at clock edge.
REQ-022 Port: timeout_err  out  1  one-cycle pulse, access aborted on timeout.

Function
REQ-023 FSM states SHALL be IDLE, RD, WR, DONE; one access in flight.
REQ-024 In IDLE with any request at edge N: gnt pulses in cycle N; addr/wdata/we/owner latch; strobe high from N+1 (RD or WR).
REQ-025 Both requesters pending: grant the one not granted last (last_grant bit); after reset data wins first tie.
REQ-026 Fetch is always a read; f_req never causes m_write.
REQ-027 In RD/WR, ready sampled high at edge M (matching strobe only): capture m_rdata (RD), strobe low at M+1, owner valid pulses at M+1, state DONE.
REQ-028 Ready on the non-active strobe, or in IDLE/DONE, SHALL be ignored.
REQ-029 DONE lasts exactly one cycle then IDLE; minimum spacing between grants is therefore 3 cycles plus memory wait.
REQ-030 Wait counter clears on strobe assertion; if TIMEOUT cycles elapse without ready: strobe drops, owner valid and timeout_err pulse together, rdata = 0, state DONE.
REQ-031 Ready arriving on the same edge the counter reaches TIMEOUT SHALL count as success, no error.
REQ-032 Store completion: d_valid pulses, d_rdata holds previous value.
REQ-033 f_rdata/d_rdata SHALL hold their last value between valid pulses.
REQ-034 Requests deasserted before grant SHALL be dropped with no response.

Reset
REQ-035 On reset edge: state IDLE, all strobes/gnt/valid/timeout_err 0, m_addr/m_wdata/rdata outputs 0, last_grant = fetch, counter 0.
REQ-036 Reset mid-access SHALL abort it: strobe low next cycle, no valid pulse for the aborted access.

Structure
REQ-037 Shared package SHALL hold ADDR_W/DATA_W defaults, mem_arb_state_t enum, and a request struct (owner, we, addr, wdata).
REQ-038 Timeout counter SHALL be sub-module mem_arb_timer (clear, enable, expired).

Verification
REQ-039 f_req only, addr 0x0010, ready after 3 cycles, m_rdata 0xA5A5 -> f_gnt at N, m_read N+1..N+4, f_valid + f_rdata 0xA5A5 at N+5.
REQ-040 d_req store addr 0x0100 data 0x1234 -> m_write with those values, d_valid pulse, d_rdata unchanged.
REQ-041 f_req and d_req held continuously for 6 accesses -> grants alternate D,F,D,F,D,F.
REQ-042 No ready with TIMEOUT=8 -> strobe drops after 8 cycles, timeout_err and f_valid same cycle, f_rdata 0.
REQ-043 reset asserted during RD -> m_read low next cycle, no f_valid, next d_req granted normally.
REQ-044 m_write_ready pulsed during RD -> ignored, access completes only on m_read_ready.
